// File: rtl/m68k_bus_pkg.sv
// Purpose : shared types and constants for the 68000 bus controller slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: FSM state enum, IACK function code, wait/watchdog field widths.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } bus_state_t;

  // Function code the 68000 drives during interrupt acknowledge.
  localparam logic [2:0] FC_IACK = 3'b111;

  // Width of one per-region wait-state field in C_REGION_WAIT.
  localparam int WAIT_W = 4;

  // Watchdog counter width; covers C_BERR_TIMEOUT up to 65535.
  localparam int WD_W = 16;

  // Maximum region count, and the index width that covers it.
  localparam int MAX_REGIONS = 8;
  localparam int MAX_IDX_W   = 3;

endpackage

// File: rtl/m68k_phi_gen.sv
// Purpose : free-running enPhi1/enPhi2 clock-enable generator for fx68k.
// Latency : registered pulses; first phi1 on the first clk edge out of reset.
// Backpr. : none, the pattern never stalls.
// Ports   : clk, reset_n (async, active low) -> phi1, phi2 one-clk pulses.
module m68k_phi_gen #(
  parameter int C_PHI_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic phi1,
  output logic phi2
);

  localparam int CW = $clog2(C_PHI_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_PHI_DIV - 1);
  localparam logic [CW-1:0] CNT_PHI2 = CW'(C_PHI_DIV / 2);

  logic [CW-1:0] cnt_q;

  // phi1 fires at count 0 and phi2 at the half-period count, so the two
  // enables can never coincide for an even divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      phi1  <= 1'b0;
      phi2  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      phi1  <= (cnt_q == '0);
      phi2  <= (cnt_q == CNT_PHI2);
    end
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// Purpose : 68000 bus controller: address decode, DTACKn/VPAn/BERRn, watchdog.
// Latency : AS low -> DTACKn low in 2 clks + wait*C_PHI_DIV + rdy stall.
// Backpr. : per-region rdy stalls the ack; watchdog ends stuck cycles with BERRn.
// Ports   : clk, reset_n; fx68k strobes/address/fc in; phi1/phi2, dtack_n,
//           vpa_n, berr_n out; sel one-hot chip selects; rdy per region in;
//           timeout sticky flag with timeout_clr.
module m68k_bus_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int C_PHI_DIV = 2,
  parameter int C_REGIONS = 4,
  parameter int C_DEC_HI  = 23,
  parameter int C_DEC_LO  = 20,
  parameter logic [C_REGIONS*(C_DEC_HI-C_DEC_LO+1)-1:0] C_REGION_MATCH =
    {4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [C_REGIONS*WAIT_W-1:0] C_REGION_WAIT = '0,
  parameter logic [C_REGIONS-1:0] C_REGION_VPA = '0,
  parameter int C_BERR_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 phi1,
  output logic                 phi2,
  input  logic                 cpu_as_n,
  input  logic                 cpu_uds_n,
  input  logic                 cpu_lds_n,
  input  logic                 cpu_rw,
  input  logic [23:1]          cpu_a,
  input  logic [2:0]           cpu_fc,
  output logic                 dtack_n,
  output logic                 vpa_n,
  output logic                 berr_n,
  output logic [C_REGIONS-1:0] sel,
  input  logic [C_REGIONS-1:0] rdy,
  output logic                 timeout,
  input  logic                 timeout_clr
);

  localparam int DW    = C_DEC_HI - C_DEC_LO + 1;
  localparam int IDX_W = (C_REGIONS > 1) ? $clog2(C_REGIONS) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(C_BERR_TIMEOUT - 1);

  // Data strobes and direction do not affect the handshake; they are only
  // consumed here so the port list stays complete for the fabric.
  logic unused_ok;
  assign unused_ok = ^{cpu_uds_n, cpu_lds_n, cpu_rw, cpu_a};

  m68k_phi_gen #(
    .C_PHI_DIV (C_PHI_DIV)
  ) u_phi (
    .clk     (clk),
    .reset_n (reset_n),
    .phi1    (phi1),
    .phi2    (phi2)
  );

  // ---------------- address decode ----------------
  logic [DW-1:0]     dec_field;
  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [WAIT_W-1:0] dec_wait;

  assign dec_field = cpu_a[C_DEC_HI:C_DEC_LO];

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = C_REGIONS - 1; i >= 0; i--) begin
      if (dec_field == C_REGION_MATCH[i*DW +: DW]) begin
        dec_hit = 1'b1;
        dec_idx = i[IDX_W-1:0];
      end
    end
  end

  assign dec_wait = C_REGION_WAIT[dec_idx*WAIT_W +: WAIT_W];

  // ---------------- FSM and counters ----------------
  bus_state_t        state_q, state_d;
  logic [IDX_W-1:0]  reg_q, reg_d;
  logic              hit_q, hit_d;
  logic              iack_q, iack_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ack_ok;

  assign ack_ok = (wcnt_q == '0) && hit_q && rdy[reg_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      hit_q   <= 1'b0;
      iack_q  <= 1'b0;
      wcnt_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      hit_q   <= hit_d;
      iack_q  <= iack_d;
      wcnt_q  <= wcnt_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    hit_d   = hit_q;
    iack_d  = iack_q;
    wcnt_d  = wcnt_q;
    wd_d    = wd_q;
    if (cpu_as_n) begin
      // Strobe released: abandon whatever was in flight.
      state_d = ST_IDLE;
      hit_d   = 1'b0;
      iack_d  = 1'b0;
      wcnt_d  = '0;
      wd_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_fc == FC_IACK) begin
            // Autovectored acknowledge: answer at once with VPAn.
            state_d = ST_ACK;
            iack_d  = 1'b1;
            hit_d   = 1'b0;
          end else begin
            state_d = ST_WAIT;
            reg_d   = dec_idx;
            hit_d   = dec_hit;
            wcnt_d  = dec_hit ? dec_wait : '0;
            wd_d    = '0;
          end
        end
        ST_WAIT: begin
          // Checking ack first lets it win over a same-clk watchdog expiry.
          if (ack_ok) begin
            state_d = ST_ACK;
          end else if (phi2) begin
            if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
            if (wd_q == WD_LAST) state_d = ST_BERR;
            else                 wd_d = wd_q + 1'b1;
          end
        end
        default: ; // ACK and BERR hold until the strobe rises
      endcase
    end
  end

  // ---------------- registered outputs ----------------
  // Outputs are computed from the next state so they change on the same
  // edge as the FSM, keeping the 2-clk ack latency.
  logic [C_REGIONS-1:0] sel_d;
  logic                 dtack_d, vpa_d, berr_d, timeout_d;

  always_comb begin
    sel_d = '0;
    if (state_d != ST_IDLE && hit_d) sel_d[reg_d] = 1'b1;
    dtack_d   = !(state_d == ST_ACK && !iack_d && !C_REGION_VPA[reg_d]);
    vpa_d     = !(state_d == ST_ACK && (iack_d || C_REGION_VPA[reg_d]));
    berr_d    = (state_d != ST_BERR);
    // Set on BERR entry outranks a simultaneous clear.
    if (state_d == ST_BERR && state_q != ST_BERR) timeout_d = 1'b1;
    else if (timeout_clr)                         timeout_d = 1'b0;
    else                                          timeout_d = timeout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dtack_n <= 1'b1;
      vpa_n   <= 1'b1;
      berr_n  <= 1'b1;
      sel     <= '0;
      timeout <= 1'b0;
    end else begin
      dtack_n <= dtack_d;
      vpa_n   <= vpa_d;
      berr_n  <= berr_d;
      sel     <= sel_d;
      timeout <= timeout_d;
    end
  end

endmodule
